// File: rtl/mollusc_pkg.sv
// Shared definitions for the mollusc core: default field layout, the decoded
// instruction bundle and the privileged-register test used by decode and regfile.
package mollusc_pkg;

    localparam int DEF_INSTR_W   = 29;
    localparam int DEF_XLEN      = 32;
    localparam int DEF_REG_AW    = 4;
    localparam int DEF_PRIV_REGS = 4;
    localparam int DEF_RD_LSB    = 24;
    localparam int DEF_RM_LSB    = 14;
    localparam int DEF_RA_LSB    = 10;
    localparam int DEF_RB_LSB    = 6;

    localparam int UPPER_IMM_W   = 22;
    localparam int LOWER_IMM_W   = 10;
    localparam int SHIFTMODE_BIT = 23;
    localparam int AUI_MODE_BIT  = 22;

    // Decoded bundle at the default widths.
    typedef struct packed {
        logic [DEF_REG_AW-1:0]  ra_d;
        logic [DEF_REG_AW-1:0]  ra_m;
        logic [DEF_REG_AW-1:0]  ra_a;
        logic [DEF_REG_AW-1:0]  ra_b;
        logic [UPPER_IMM_W-1:0] upper_imm;
        logic [LOWER_IMM_W-1:0] lower_imm;
        logic                   shiftmode;
        logic                   aui_mode;
        logic [DEF_XLEN-1:0]    aui_val;
        logic [DEF_XLEN-1:0]    pc;
        logic                   priv;
        logic                   priv_fault;
    } decoded_t;

    // The top priv_regs addresses of the register file are privileged.
    function automatic logic is_priv_reg(input int unsigned addr,
                                         input int unsigned priv_regs,
                                         input int unsigned reg_aw = DEF_REG_AW);
        return (priv_regs != 0) && (addr >= ((32'd1 << reg_aw) - priv_regs));
    endfunction

endpackage

// File: rtl/skid_buffer.sv
// Two-entry valid/ready pipeline register (main output register plus one skid
// entry); in_ready depends only on registered state.
module skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic [WIDTH-1:0] main_reg;
    logic [WIDTH-1:0] skid_reg;
    logic             main_valid_reg;
    logic             skid_valid_reg;
    logic             accept;
    logic             consume;

    assign in_ready  = !skid_valid_reg;
    assign out_valid = main_valid_reg;
    assign out_data  = main_reg;

    assign accept  = in_valid && in_ready && !flush;
    assign consume = main_valid_reg && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            main_reg       <= '0;
            skid_reg       <= '0;
            main_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
        end else if (flush) begin
            main_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
        end else if (consume) begin
            if (skid_valid_reg) begin
                // Skid drains into main; in_ready was low so nothing new arrives.
                main_reg       <= skid_reg;
                main_valid_reg <= 1'b1;
                skid_valid_reg <= 1'b0;
            end else begin
                main_valid_reg <= accept;
                if (accept) begin
                    main_reg <= in_data;
                end
            end
        end else if (!main_valid_reg) begin
            main_valid_reg <= accept;
            if (accept) begin
                main_reg <= in_data;
            end
        end else if (accept) begin
            skid_reg       <= in_data;
            skid_valid_reg <= 1'b1;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Mollusc decode stage: splits the instruction into register fields and
// immediates, computes the AUI value and privilege fault, behind a skid buffer.
module decode_stage
    import mollusc_pkg::*;
#(
    parameter int INSTR_W   = DEF_INSTR_W,
    parameter int XLEN      = DEF_XLEN,
    parameter int REG_AW    = DEF_REG_AW,
    parameter int PRIV_REGS = DEF_PRIV_REGS,
    parameter int RD_LSB    = DEF_RD_LSB,
    parameter int RM_LSB    = DEF_RM_LSB,
    parameter int RA_LSB    = DEF_RA_LSB,
    parameter int RB_LSB    = DEF_RB_LSB
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [XLEN-1:0]    in_pc,
    input  logic               in_priv,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [REG_AW-1:0]  out_ra_d,
    output logic [REG_AW-1:0]  out_ra_m,
    output logic [REG_AW-1:0]  out_ra_a,
    output logic [REG_AW-1:0]  out_ra_b,
    output logic [21:0]        out_upper_imm,
    output logic [9:0]         out_lower_imm,
    output logic               out_shiftmode,
    output logic               out_aui_mode,
    output logic [XLEN-1:0]    out_aui_val,
    output logic [XLEN-1:0]    out_pc,
    output logic               out_priv,
    output logic               out_priv_fault,
    output logic [15:0]        fault_count
);

    typedef struct packed {
        logic [REG_AW-1:0]      ra_d;
        logic [REG_AW-1:0]      ra_m;
        logic [REG_AW-1:0]      ra_a;
        logic [REG_AW-1:0]      ra_b;
        logic [UPPER_IMM_W-1:0] upper_imm;
        logic [LOWER_IMM_W-1:0] lower_imm;
        logic                   shiftmode;
        logic                   aui_mode;
        logic [XLEN-1:0]        aui_val;
        logic [XLEN-1:0]        pc;
        logic                   priv;
        logic                   priv_fault;
    } bundle_t;

    localparam int BUNDLE_W  = $bits(bundle_t);
    localparam int NUM_FIELD = 4;
    localparam int FIELD_LSB [NUM_FIELD] = '{RD_LSB, RM_LSB, RA_LSB, RB_LSB};
    localparam int EXT_W     = (XLEN > 32) ? XLEN : 32;

    if (INSTR_W < 24) begin : g_bad_instr_w
        $error("decode_stage: INSTR_W must be at least 24");
    end

    logic [REG_AW-1:0]    field_addr [NUM_FIELD];
    logic [NUM_FIELD-1:0] field_priv;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_FIELD; gi++) begin : g_field
            if (FIELD_LSB[gi] + REG_AW > INSTR_W) begin : g_bad_field
                $error("decode_stage: register field exceeds INSTR_W");
            end
            assign field_addr[gi] = in_instr[FIELD_LSB[gi] +: REG_AW];
            assign field_priv[gi] = is_priv_reg(32'(field_addr[gi]), PRIV_REGS, REG_AW);
        end
    endgenerate

    bundle_t             dec_bundle;
    bundle_t             out_bundle;
    logic [BUNDLE_W-1:0] out_bits;
    logic [EXT_W-1:0]    imm_wide;
    logic [XLEN-1:0]     aui_base;

    always_comb begin
        dec_bundle            = '0;
        dec_bundle.ra_d       = field_addr[0];
        dec_bundle.ra_m       = field_addr[1];
        dec_bundle.ra_a       = field_addr[2];
        dec_bundle.ra_b       = field_addr[3];
        dec_bundle.upper_imm  = in_instr[UPPER_IMM_W-1:0];
        dec_bundle.lower_imm  = in_instr[LOWER_IMM_W-1:0];
        dec_bundle.shiftmode  = in_instr[SHIFTMODE_BIT];
        dec_bundle.aui_mode   = in_instr[AUI_MODE_BIT];
        dec_bundle.pc         = in_pc;
        dec_bundle.priv       = in_priv;
        dec_bundle.priv_fault = !in_priv && (|field_priv);

        // Zero-extend before truncating so narrow XLEN simply drops high bits.
        imm_wide = dec_bundle.shiftmode ? EXT_W'({dec_bundle.upper_imm, 10'b0})
                                        : EXT_W'({dec_bundle.upper_imm, 2'b0});
        aui_base = dec_bundle.aui_mode ? in_pc : '0;
        dec_bundle.aui_val = aui_base + imm_wide[XLEN-1:0];
    end

    skid_buffer #(
        .WIDTH(BUNDLE_W)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (dec_bundle),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_bits)
    );

    assign out_bundle     = bundle_t'(out_bits);
    assign out_ra_d       = out_bundle.ra_d;
    assign out_ra_m       = out_bundle.ra_m;
    assign out_ra_a       = out_bundle.ra_a;
    assign out_ra_b       = out_bundle.ra_b;
    assign out_upper_imm  = out_bundle.upper_imm;
    assign out_lower_imm  = out_bundle.lower_imm;
    assign out_shiftmode  = out_bundle.shiftmode;
    assign out_aui_mode   = out_bundle.aui_mode;
    assign out_aui_val    = out_bundle.aui_val;
    assign out_pc         = out_bundle.pc;
    assign out_priv       = out_bundle.priv;
    assign out_priv_fault = out_bundle.priv_fault;

    logic [15:0] fault_count_reg;
    assign fault_count = fault_count_reg;

    // Counts completed handshakes, so a same-cycle flush still counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_count_reg <= '0;
        end else if (out_valid && out_ready && out_bundle.priv_fault
                     && fault_count_reg != 16'hFFFF) begin
            fault_count_reg <= fault_count_reg + 16'd1;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: vector table for decode/AUI/fault, then
// stall, flush and fault-counter saturation sequences.
module tb_decode_stage;

    localparam int INSTR_W = 29;
    localparam int XLEN    = 32;
    localparam int REG_AW  = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] in_instr;
    logic [XLEN-1:0]    in_pc;
    logic               in_priv;
    logic               out_valid;
    logic               out_ready;
    logic [REG_AW-1:0]  out_ra_d, out_ra_m, out_ra_a, out_ra_b;
    logic [21:0]        out_upper_imm;
    logic [9:0]         out_lower_imm;
    logic               out_shiftmode, out_aui_mode;
    logic [XLEN-1:0]    out_aui_val, out_pc;
    logic               out_priv, out_priv_fault;
    logic [15:0]        fault_count;

    decode_stage #(
        .INSTR_W(INSTR_W), .XLEN(XLEN), .REG_AW(REG_AW), .PRIV_REGS(4),
        .RD_LSB(24), .RM_LSB(14), .RA_LSB(10), .RB_LSB(6)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_pc(in_pc), .in_priv(in_priv),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ra_d(out_ra_d), .out_ra_m(out_ra_m), .out_ra_a(out_ra_a), .out_ra_b(out_ra_b),
        .out_upper_imm(out_upper_imm), .out_lower_imm(out_lower_imm),
        .out_shiftmode(out_shiftmode), .out_aui_mode(out_aui_mode),
        .out_aui_val(out_aui_val), .out_pc(out_pc), .out_priv(out_priv),
        .out_priv_fault(out_priv_fault), .fault_count(fault_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        priv;
        logic [3:0]  ra_d, ra_m, ra_a, ra_b;
        logic [21:0] upper;
        logic [9:0]  lower;
        logic        shiftmode, aui_mode;
        logic [31:0] aui_val;
        logic        fault;
    } vec_t;

    vec_t        vecs [9];
    int          checks = 0;
    int          errors = 0;
    int unsigned exp_fc = 0;
    int          not_ready_cycles;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic present(input logic [31:0] instr, input logic [31:0] pc, input logic priv);
        in_valid = 1'b1;
        in_instr = instr[INSTR_W-1:0];
        in_pc    = pc;
        in_priv  = priv;
    endtask

    initial begin
        //            instr         pc            pv rd  rm  ra  rb  upper      lower   sm aui aui_val       flt
        vecs[0] = '{32'h0F00_0000, 32'h0000_0000, 0, 15,  0,  0,  0, 22'h0,     10'h0,   0, 0, 32'h0000_0000, 1};
        vecs[1] = '{32'h00C0_0001, 32'h0000_0100, 0,  0,  0,  0,  0, 22'h1,     10'h1,   1, 1, 32'h0000_0500, 0};
        vecs[2] = '{32'h0000_0001, 32'h0000_0100, 0,  0,  0,  0,  0, 22'h1,     10'h1,   0, 0, 32'h0000_0004, 0};
        vecs[3] = '{32'h0040_0001, 32'hFFFF_FFFC, 0,  0,  0,  0,  0, 22'h1,     10'h1,   0, 1, 32'h0000_0000, 0};
        vecs[4] = '{32'h0F00_0000, 32'h0000_0040, 1, 15,  0,  0,  0, 22'h0,     10'h0,   0, 0, 32'h0000_0000, 0};
        vecs[5] = '{32'h0003_0000, 32'h0000_0000, 0,  0, 12,  0,  0, 22'h30000, 10'h0,   0, 0, 32'h000C_0000, 1};
        vecs[6] = '{32'h0000_0340, 32'h0000_0000, 0,  0,  0,  0, 13, 22'h340,   10'h340, 0, 0, 32'h0000_0D00, 1};
        vecs[7] = '{32'h00C0_2EC0, 32'h0000_1000, 0,  0,  0, 11, 11, 22'h2EC0,  10'h2C0, 1, 1, 32'h00BB_1000, 0};
        vecs[8] = '{32'h00BF_FFFF, 32'h0000_0000, 0,  0, 15, 15, 15, 22'h3FFFFF,10'h3FF, 1, 0, 32'hFFFF_FC00, 1};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
        in_priv = 1'b0; out_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        check("reset_out_valid", 32'(out_valid), 0);
        check("reset_in_ready", 32'(in_ready), 1);
        check("reset_fault_count", 32'(fault_count), 0);
        check("reset_aui_val", out_aui_val, 0);
        check("reset_ra_d", 32'(out_ra_d), 0);

        // Table: one instruction at a time through an empty stage.
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            present(vecs[i].instr, vecs[i].pc, vecs[i].priv);
            tick();
            in_valid = 1'b0;
            check("vec_out_valid", 32'(out_valid), 1);
            check("vec_ra_d", 32'(out_ra_d), 32'(vecs[i].ra_d));
            check("vec_ra_m", 32'(out_ra_m), 32'(vecs[i].ra_m));
            check("vec_ra_a", 32'(out_ra_a), 32'(vecs[i].ra_a));
            check("vec_ra_b", 32'(out_ra_b), 32'(vecs[i].ra_b));
            check("vec_upper_imm", 32'(out_upper_imm), 32'(vecs[i].upper));
            check("vec_lower_imm", 32'(out_lower_imm), 32'(vecs[i].lower));
            check("vec_shiftmode", 32'(out_shiftmode), 32'(vecs[i].shiftmode));
            check("vec_aui_mode", 32'(out_aui_mode), 32'(vecs[i].aui_mode));
            check("vec_aui_val", out_aui_val, vecs[i].aui_val);
            check("vec_pc", out_pc, vecs[i].pc);
            check("vec_priv", 32'(out_priv), 32'(vecs[i].priv));
            check("vec_priv_fault", 32'(out_priv_fault), 32'(vecs[i].fault));
            tick();
            if (vecs[i].fault) exp_fc++;
            check("vec_fault_count", 32'(fault_count), exp_fc);
            check("vec_drained", 32'(out_valid), 0);
            $display("vec %0d instr=0x%0h pc=0x%0h aui_val=0x%0h fault=%0d fc=%0d",
                     i, vecs[i].instr, vecs[i].pc, out_aui_val, out_priv_fault, fault_count);
        end

        // Stall: three instructions against out_ready=0.
        out_ready = 1'b0;
        present(32'h0, 32'h10, 1'b0);
        tick();
        check("stall_ready_after_1", 32'(in_ready), 1);
        present(32'h0, 32'h20, 1'b0);
        tick();
        check("stall_ready_after_2", 32'(in_ready), 0);
        present(32'h0, 32'h30, 1'b0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("stall_out_valid", 32'(out_valid), 1);
            check("stall_hold_pc", out_pc, 32'h10);
            check("stall_in_ready", 32'(in_ready), 0);
        end
        out_ready = 1'b1;
        tick();
        check("drain_1_valid", 32'(out_valid), 1);
        check("drain_1_pc", out_pc, 32'h20);
        check("drain_1_in_ready", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        check("drain_2_valid", 32'(out_valid), 1);
        check("drain_2_pc", out_pc, 32'h30);
        tick();
        check("drain_empty", 32'(out_valid), 0);
        $display("stall sequence done");

        // Flush with main and skid full of faulting instructions.
        out_ready = 1'b0;
        present(32'h0F00_0000, 32'h40, 1'b0);
        tick();
        present(32'h0F00_0000, 32'h50, 1'b0);
        tick();
        check("preflush_skid_full", 32'(in_ready), 0);
        present(32'h0F00_0000, 32'h60, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", 32'(out_valid), 0);
        check("flush_in_ready", 32'(in_ready), 1);
        // Flush on an empty stage with in_ready=1 must still drop the input.
        present(32'h0F00_0000, 32'h70, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("flush_ready_drop", 32'(out_valid), 0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("postflush_silent", 32'(out_valid), 0);
        end
        check("flush_fault_count", 32'(fault_count), exp_fc);
        $display("flush sequence done fc=%0d", fault_count);

        // Saturation: stream faulting instructions at full rate.
        not_ready_cycles = 0;
        present(32'h0F00_0000, 32'h0, 1'b0);
        for (int c = 0; c < 65534 - int'(exp_fc); c++) begin
            tick();
            if (!in_ready) not_ready_cycles++;
        end
        in_valid = 1'b0;
        tick();
        tick();
        check("stream_full_rate", 32'(not_ready_cycles), 0);
        check("sat_fault_count_fffe", 32'(fault_count), 32'hFFFE);
        for (int k = 0; k < 3; k++) begin
            present(32'h0F00_0000, 32'h0, 1'b0);
            tick();
            in_valid = 1'b0;
            tick();
            check("sat_fault_count", 32'(fault_count), 32'hFFFF);
            $display("saturation step %0d fc=0x%0h", k, fault_count);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
